// File: rtl/rv32_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package rv32_pkg;

    // Arbiter FSM: one memory transaction in flight at a time.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Which requester owns the current transaction.
    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } arb_src_t;

    // Consecutive data grants tolerated while a fetch is pending.
    localparam int unsigned ARB_STARVE_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto a single memory port.
// Data wins by default; a waiting fetch is forced through after STARVE_MAX
// back-to-back data grants. A killed fetch is either aborted before the
// memory accepts it, or completed silently once the memory owns it.
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    // Fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    // Data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // Shared memory port
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_t      state_q, state_d;
    arb_src_t        src_q, src_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            we_q, we_d;
    logic            drop_q, drop_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic starved;
    logic fetch_sel;
    logic fetch_owned;

    assign starved     = (starve_q == CntW'(STARVE_MAX));
    assign fetch_sel   = if_req && (!d_req || starved);
    assign fetch_owned = (src_q == SRC_IF);

    // Next-state, captured request and memory/response outputs.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        drop_d    = drop_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (if_req || d_req) begin
                    state_d = ISSUE;
                    if (fetch_sel) begin
                        src_d   = SRC_IF;
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end else begin
                        src_d   = SRC_D;
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        wstrb_d = d_wstrb;
                    end
                end
            end
            ISSUE: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_wstrb = wstrb_q;
                // Not yet accepted: a kill can still cancel with no memory access.
                if (fetch_owned && if_kill && !mem_gnt) begin
                    state_d = IDLE;
                end else if (mem_gnt) begin
                    state_d = WAIT;
                    if (fetch_owned && if_kill) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (fetch_owned && if_kill) begin
                    drop_d = 1'b1;
                end
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (!fetch_owned) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else if (!drop_q && !if_kill) begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter: consecutive data grants made while a fetch waits.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            if (fetch_sel) begin
                starve_d = '0;
            end else if (d_req && !starved) begin
                starve_d = starve_q + CntW'(1);
            end
        end
    end

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            src_q    <= SRC_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            we_q     <= 1'b0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            we_q     <= we_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model plus a randomized memory.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk, rst_n;
    logic        if_req, if_kill, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_port_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Memory responder knobs and state
    int          gnt_prob = 100;
    int          rv_min = 0, rv_max = 0;
    bit          spurious = 1'b0;
    logic [31:0] rmem [logic [31:0]];
    bit          r_pend = 1'b0;
    int          r_cnt = 0;
    logic [31:0] r_data = '0;

    // Transaction-level reference model
    logic [31:0] shadow [logic [31:0]];
    bit          m_busy = 0, m_gnt = 0, m_is_d = 0, m_we = 0, m_drop = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [3:0]  m_strb = '0;
    int          m_starve = 0;

    // Observations taken at the falling edge
    bit          obs_if_rvalid, obs_d_rvalid, obs_mem_rvalid, obs_mem_req;
    logic [31:0] obs_if_rdata, obs_d_rdata;
    bit          acc_we[$];
    logic [31:0] acc_addr[$];
    logic [31:0] last_if, last_d;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_rmem(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] rd_shadow(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk1(input string name, input bit act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        rmem[a]   = v;
        shadow[a] = v;
    endtask

    // Advance the model over one rising edge using this cycle's inputs.
    task automatic model_tick();
        bit took_if, took_d;
        took_if = 0;
        took_d  = 0;
        if (!rst_n) begin
            m_busy = 0; m_gnt = 0; m_drop = 0; m_starve = 0;
            return;
        end
        if (!m_busy) begin
            if (if_req || d_req) begin
                took_if = if_req && (!d_req || m_starve == STARVE);
                took_d  = !took_if;
                m_busy = 1; m_gnt = 0; m_drop = 0; m_is_d = took_d;
                m_we    = took_d ? d_we : 1'b0;
                m_addr  = took_d ? d_addr : if_addr;
                m_wdata = took_d ? d_wdata : 32'h0;
                m_strb  = took_d ? d_wstrb : 4'h0;
            end
        end else if (!m_gnt) begin
            if (!m_is_d && if_kill && !mem_gnt) begin
                m_busy = 0;
            end else if (mem_gnt) begin
                m_gnt = 1;
                if (!m_is_d && if_kill) m_drop = 1;
                if (m_we) shadow[m_addr] = merge(rd_shadow(m_addr), m_wdata, m_strb);
                else m_rdata = rd_shadow(m_addr);
            end
        end else begin
            if (!m_is_d && if_kill) m_drop = 1;
            if (mem_rvalid) m_busy = 0;
        end
        if (!if_req || took_if) m_starve = 0;
        else if (took_d && m_starve < STARVE) m_starve = m_starve + 1;
    endtask

    // One clock: compare at the falling edge, advance model and memory, then
    // drive the memory's inputs for the next cycle just after the rising edge.
    task automatic step();
        bit          e_req, e_ifv, e_dv;
        logic [31:0] e_ifd, e_dd;
        @(negedge clk);
        e_req = 0; e_ifv = 0; e_dv = 0; e_ifd = '0; e_dd = '0;
        if (rst_n && m_busy) begin
            if (!m_gnt) begin
                e_req = 1;
            end else if (mem_rvalid) begin
                if (m_is_d) begin
                    e_dv = 1;
                    e_dd = m_we ? mem_rdata : m_rdata;
                end else if (!m_drop && !if_kill) begin
                    e_ifv = 1;
                    e_ifd = m_rdata;
                end
            end
        end
        chk1("mem_req", mem_req, e_req);
        if (e_req) begin
            chk1("mem_we", mem_we, m_we);
            chk32("mem_addr", mem_addr, m_addr);
            chk32("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m_strb});
            if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
        end else if (!rst_n) begin
            chk1("rst_mem_we", mem_we, 1'b0);
            chk32("rst_mem_addr", mem_addr, 32'h0);
            chk32("rst_mem_wdata", mem_wdata, 32'h0);
            chk32("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        end
        chk1("if_rvalid", if_rvalid, e_ifv);
        chk32("if_rdata", if_rdata, e_ifd);
        chk1("d_rvalid", d_rvalid, e_dv);
        chk32("d_rdata", d_rdata, e_dd);

        obs_if_rvalid  = if_rvalid;
        obs_if_rdata   = if_rdata;
        obs_d_rvalid   = d_rvalid;
        obs_d_rdata    = d_rdata;
        obs_mem_rvalid = mem_rvalid;
        obs_mem_req    = mem_req;

        if (rst_n && mem_req && mem_gnt) begin
            chk1("one_outstanding", r_pend, 1'b0);
            acc_we.push_back(mem_we);
            acc_addr.push_back(mem_addr);
            if (mem_we) begin
                rmem[mem_addr] = merge(rd_rmem(mem_addr), mem_wdata, mem_wstrb);
                r_data = $urandom;
            end else begin
                r_data = rd_rmem(mem_addr);
            end
            r_pend = 1;
            r_cnt  = int'($urandom_range(rv_max, rv_min));
        end
        model_tick();

        @(posedge clk);
        #1;
        mem_gnt = (int'($urandom_range(99, 0)) < gnt_prob);
        if (r_pend && r_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = r_data;
            r_pend     = 0;
        end else begin
            mem_rvalid = spurious && !r_pend && ($urandom_range(7, 0) == 0);
            mem_rdata  = $urandom;
            if (r_pend) r_cnt--;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Run until both requesters have seen their responses (bounded).
    task automatic serve(input int budget, input string tag);
        int n;
        n = 0;
        while ((if_req || d_req) && n < budget) begin
            step();
            n++;
            if (obs_if_rvalid) begin if_req = 0; last_if = obs_if_rdata; end
            if (obs_d_rvalid) begin d_req = 0; last_d = obs_d_rdata; end
        end
        chk1({tag, "_done"}, !(if_req || d_req), 1'b1);
        if_req = 0;
        d_req  = 0;
    endtask

    task automatic new_d();
        d_req   = 1;
        d_we    = ($urandom_range(1, 0) == 1);
        d_addr  = 32'($urandom_range(63, 0)) << 2;
        d_wdata = $urandom;
        d_wstrb = 4'($urandom_range(15, 0));
    endtask

    initial begin
        int          n, cnt_a, cnt_b;
        bit          got, prev_kill;
        logic [31:0] rd;
        logic [31:0] exp22 [7];

        rst_n = 1; if_req = 0; if_addr = '0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        last_if = '0; last_d = '0;

        // Reset
        #2 rst_n = 0;
        #1;
        chk1("reset_mem_req", mem_req, 1'b0);
        chk1("reset_if_rvalid", if_rvalid, 1'b0);
        chk1("reset_d_rvalid", d_rvalid, 1'b0);
        idle(2);
        rst_n = 1;
        step();

        // Lone fetch: response lands in the third cycle
        preload(32'h100, 32'h0050_0093);
        if_req = 1; if_addr = 32'h100;
        n = 0; got = 0; cnt_a = 0; rd = '0;
        while (!got && n < 20) begin
            step();
            n++;
            if (obs_d_rvalid) cnt_a++;
            if (obs_if_rvalid) begin got = 1; rd = obs_if_rdata; end
        end
        if_req = 0;
        chk32("req020_latency", n, 3);
        chk32("req020_if_rdata", rd, 32'h0050_0093);
        chk32("req020_no_d_rvalid", cnt_a, 0);
        idle(1);

        // Simultaneous store and fetch: store goes first
        preload(32'h200, 32'h1111_1111);
        preload(32'h104, 32'h0000_0013);
        acc_we.delete(); acc_addr.delete();
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        serve(40, "req021");
        chk32("req021_count", acc_we.size(), 2);
        chk1("req021_first_we", acc_we.size() > 0 ? acc_we[0] : 1'b0, 1'b1);
        chk32("req021_first_addr", acc_addr.size() > 0 ? acc_addr[0] : 32'h0, 32'h200);
        chk1("req021_second_we", acc_we.size() > 1 ? acc_we[1] : 1'b1, 1'b0);
        chk32("req021_second_addr", acc_addr.size() > 1 ? acc_addr[1] : 32'h0, 32'h104);
        chk32("req021_fetch_data", last_if, 32'h0000_0013);
        chk32("req021_mem_contents", rd_rmem(32'h200), 32'hDEAD_BEEF);
        d_req = 1; d_we = 0; d_addr = 32'h200;
        serve(20, "req021_readback");
        chk32("req021_load_data", last_d, 32'hDEAD_BEEF);

        // Starvation: four data grants, one fetch, then data again
        exp22 = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'h400, 32'h810, 32'h814};
        acc_we.delete(); acc_addr.delete();
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_we = 0; d_addr = 32'h800;
        n = 0;
        while (acc_addr.size() < 7 && n < 80) begin
            step();
            n++;
            if (obs_d_rvalid) d_addr = d_addr + 32'h4;
        end
        for (int i = 0; i < 7; i++)
            chk32($sformatf("req022_grant%0d", i),
                  i < acc_addr.size() ? acc_addr[i] : 32'hFFFF_FFFF, exp22[i]);
        if_req = 0; d_req = 0;
        idle(6);

        // Fetch killed before the memory accepts it
        gnt_prob = 0;
        acc_we.delete(); acc_addr.delete();
        cnt_a = 0;
        if_req = 1; if_addr = 32'h108;
        step();
        if (obs_if_rvalid) cnt_a++;
        if_kill = 1;
        step();
        if (obs_if_rvalid) cnt_a++;
        chk1("req023_issue_req", obs_mem_req, 1'b1);
        if_kill = 0; if_req = 0;
        step();
        if (obs_if_rvalid) cnt_a++;
        chk1("req023_idle_after_kill", obs_mem_req, 1'b0);
        step();
        if (obs_if_rvalid) cnt_a++;
        chk32("req023_no_accept", acc_addr.size(), 0);
        chk32("req023_no_if_rvalid", cnt_a, 0);
        gnt_prob = 100;

        // Fetch killed while the memory owns it
        rv_min = 2; rv_max = 2;
        acc_we.delete(); acc_addr.delete();
        if_req = 1; if_addr = 32'h10C;
        idle(2);
        if_kill = 1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if_kill = 0; if_req = 0;
            if (obs_mem_rvalid) cnt_a++;
            if (obs_if_rvalid) cnt_b++;
        end
        chk32("req023_wait_accept", acc_addr.size(), 1);
        chk32("req023_wait_mem_rvalid", cnt_a, 1);
        chk32("req023_wait_no_if_rvalid", cnt_b, 0);
        rv_min = 0; rv_max = 0;

        // Reset while the memory request is being presented
        gnt_prob = 0;
        preload(32'h300, 32'h1234_5678);
        d_req = 1; d_we = 0; d_addr = 32'h300;
        idle(2);
        chk1("rst_issue_req_before", obs_mem_req, 1'b1);
        rst_n = 0; d_req = 0;
        #1;
        chk1("rst_issue_req_now", mem_req, 1'b0);
        chk32("rst_issue_addr_now", mem_addr, 32'h0);
        step();
        rst_n = 1;
        gnt_prob = 100;
        step();

        // Reset during WAIT of a load; the late response must be ignored
        rv_min = 3; rv_max = 3;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        idle(2);
        rst_n = 0; d_req = 0;
        #1;
        chk1("req024_mem_req", mem_req, 1'b0);
        chk1("req024_d_rvalid", d_rvalid, 1'b0);
        chk32("req024_d_rdata", d_rdata, 32'h0);
        chk1("req024_if_rvalid", if_rvalid, 1'b0);
        step();
        rst_n = 1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_mem_rvalid) cnt_a++;
            if (obs_d_rvalid) cnt_b++;
        end
        chk32("req024_late_rvalid_seen", cnt_a, 1);
        chk32("req024_late_rvalid_ignored", cnt_b, 0);
        rv_min = 0; rv_max = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        serve(20, "req024_reload");
        chk32("req024_reload_data", last_d, 32'h1234_5678);

        // Randomized traffic against the model
        gnt_prob = 60; rv_min = 0; rv_max = 3; spurious = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            prev_kill = if_kill;
            if_kill = 0;
            if (prev_kill) begin
                if_req = 0;
            end else if (if_req && obs_if_rvalid) begin
                if_req = 0;
            end else if (!if_req && $urandom_range(9, 0) < 4) begin
                if_req  = 1;
                if_addr = 32'($urandom_range(63, 0)) << 2;
            end
            if_kill = ($urandom_range(11, 0) == 0);
            if (d_req && obs_d_rvalid) begin
                if ($urandom_range(1, 0) == 1) new_d();
                else d_req = 0;
            end else if (!d_req && $urandom_range(9, 0) < 5) begin
                new_d();
            end
        end
        if_req = 0; d_req = 0; if_kill = 0; spurious = 0;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
